ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor, the successor to the fixed 8-bit combinational prefix adder. It supports arbitrary operand width, carry-in, subtract mode, carry-out and signed overflow, with optional registering of every prefix level. A valid/ready handshake with global stall lets it sit directly in the instrumented datapath between operand source and result sink.

---
 rtl/ks_adder_pipe.sv | 142 ++++++++++++++
 tb/tb_ks_adder_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake and global stall.
// Input stage conditions operands into bit G/P/X; each prefix level is optionally registered.
module ks_adder_pipe #(
    parameter int WIDTH     = 8,
    parameter int PIPELINED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int LEVELS = $clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] b_cond, g_bit, p_bit, x_bit;
    logic             c_cond;

    logic [WIDTH-1:0] g0_q, p0_q, x0_q;
    logic             c0_q, v0_q;

    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // Subtraction is A + ~B + ~borrow, so carry_out = 1 means no borrow.
    always_comb begin
        b_cond   = sub ? ~b_in : b_in;
        c_cond   = sub ? ~carry_in : carry_in;
        p_bit    = a_in | b_cond;
        g_bit    = a_in & b_cond;
        g_bit[0] = g_bit[0] | (p_bit[0] & c_cond);
        x_bit    = a_in ^ b_cond;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q <= 1'b0;
            g0_q <= '0;
            p0_q <= '0;
            x0_q <= '0;
            c0_q <= 1'b0;
        end else if (advance) begin
            v0_q <= in_valid;
            g0_q <= g_bit;
            p0_q <= p_bit;
            x0_q <= x_bit;
            c0_q <= c_cond;
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int SPAN = 1 << (l - 1);
        localparam logic [WIDTH-1:0] LOW = WIDTH'((64'(1) << SPAN) - 64'(1));

        logic [WIDTH-1:0] g_in, p_in, x_in, g_nx, g_out, x_out;
        logic             c0_in, v_in, c0_out, v_out;

        if (l == 1) begin : g_first
            assign g_in  = g0_q;
            assign p_in  = p0_q;
            assign x_in  = x0_q;
            assign c0_in = c0_q;
            assign v_in  = v0_q;
        end else begin : g_next
            assign g_in  = g_level[l-1].g_out;
            assign p_in  = g_level[l-1].g_pass.p_out;
            assign x_in  = g_level[l-1].x_out;
            assign c0_in = g_level[l-1].c0_out;
            assign v_in  = g_level[l-1].v_out;
        end

        // Shifting in zeros leaves bits whose span reaches below bit 0 unchanged.
        assign g_nx = g_in | (p_in & (g_in << SPAN));

        if (l < LEVELS) begin : g_pass
            logic [WIDTH-1:0] p_nx, p_out;
            assign p_nx = p_in & ((p_in << SPAN) | LOW);
            if (PIPELINED != 0) begin : g_reg
                always_ff @(posedge clk) begin
                    if (reset) p_out <= '0;
                    else if (advance) p_out <= p_nx;
                end
            end else begin : g_wire
                assign p_out = p_nx;
            end
        end

        if (PIPELINED != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    g_out  <= '0;
                    x_out  <= '0;
                    c0_out <= 1'b0;
                    v_out  <= 1'b0;
                end else if (advance) begin
                    g_out  <= g_nx;
                    x_out  <= x_in;
                    c0_out <= c0_in;
                    v_out  <= v_in;
                end
            end
        end else begin : g_wire
            assign g_out  = g_nx;
            assign x_out  = x_in;
            assign c0_out = c0_in;
            assign v_out  = v_in;
        end
    end

    logic [WIDTH-1:0] g_fin, x_fin;
    logic             c0_fin, v_fin;

    assign g_fin  = g_level[LEVELS].g_out;
    assign x_fin  = g_level[LEVELS].x_out;
    assign c0_fin = g_level[LEVELS].c0_out;
    assign v_fin  = g_level[LEVELS].v_out;

    // Carry into bit i is the group generate of bits i-1..0; bit 0 takes the conditioned carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= v_fin;
            sum       <= x_fin ^ {g_fin[WIDTH-2:0], c0_fin};
            carry_out <= g_fin[WIDTH-1];
            overflow  <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe: one DUT per width/pipelining configuration,
// each with a directed table, backpressure and reset sequences, then a random scoreboard run.
module tb_ks_adder_pipe;

    localparam int NCFG = 8;

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int W = (k / 2 == 0) ? 8 : (k / 2 == 1) ? 2 : (k / 2 == 2) ? 13 : 32;
        localparam int P = (k % 2 == 0) ? 1 : 0;
        localparam int L = (P != 0) ? $clog2(W) + 2 : 2;
        localparam int NRAND = 1500;
        localparam logic [W-1:0] ONES = {W{1'b1}};
        localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
        localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

        typedef struct {
            logic [W-1:0] sum;
            logic         co;
            logic         ov;
            int           acc;
            bit           lat;
        } exp_t;

        typedef struct {
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         cin;
            logic         sub;
            logic [W-1:0] sum;
            logic         co;
            logic         ov;
        } vec_t;

        logic         rst, in_valid, in_ready, carry_in, sub, out_valid, out_ready;
        logic         carry_out, overflow;
        logic [W-1:0] a_in, b_in, sum;

        exp_t sb[$];
        vec_t tbl[7];
        int   cyc = 0;

        ks_adder_pipe #(.WIDTH(W), .PIPELINED(P)) dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a_in      (a_in),
            .b_in      (b_in),
            .carry_in  (carry_in),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .carry_out (carry_out),
            .overflow  (overflow)
        );

        function automatic string tag(input string s);
            return $sformatf("cfg%0d(W=%0d,P=%0d) %s", k, W, P, s);
        endfunction

        function automatic longint sval(input logic [W-1:0] v);
            return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
        endfunction

        // Integer arithmetic reference: unsigned for sum/carry, signed range for overflow.
        function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic s);
            exp_t   e;
            longint r, sr, cl;
            cl    = longint'(ci);
            r     = s ? longint'(a) - longint'(b) - cl : longint'(a) + longint'(b) + cl;
            sr    = s ? sval(a) - sval(b) - cl : sval(a) + sval(b) + cl;
            e.sum = r[W-1:0];
            e.co  = s ? (r >= 0) : (r >= (longint'(1) << W));
            e.ov  = (sr > sval(MAXP)) || (sr < sval(MINN));
            e.acc = 0;
            e.lat = 1'b0;
            return e;
        endfunction

        task automatic checkOutput(input logic rs);
            exp_t e;
            if (!rs && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s: got result 0x%0h with nothing outstanding, expected no result",
                             tag("spurious"), sum);
                end else begin
                    e = sb.pop_front();
                    checkEq(tag("sum"), 32'(sum), 32'(e.sum));
                    checkEq(tag("carry_out"), 32'(carry_out), 32'(e.co));
                    checkEq(tag("overflow"), 32'(overflow), 32'(e.ov));
                    if (e.lat) checkEq(tag("latency"), cyc - e.acc, L);
                end
            end
        endtask

        task automatic driveAndCheck(input logic rs, input logic iv, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci, input logic s,
                                     input logic ordy, input exp_t e, output logic acc);
            rst       = rs;
            in_valid  = iv;
            a_in      = a;
            b_in      = b;
            carry_in  = ci;
            sub       = s;
            out_ready = ordy;
            #1;
            cyc++;
            checkOutput(rs);
            acc = 1'b0;
            if (rs) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                e.acc = cyc;
                sb.push_back(e);
                acc = 1'b1;
            end
        endtask

        task automatic applyStimulus(input logic rs, input logic iv, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci, input logic s,
                                     input logic ordy, input exp_t e, output logic acc);
            @(negedge clk);
            driveAndCheck(rs, iv, a, b, ci, s, ordy, e, acc);
        endtask

        task automatic idle(input logic ordy);
            logic acc;
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ordy, model('0, '0, 1'b0, 1'b0), acc);
        endtask

        task automatic sendBeat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                input logic s, input logic ordy, input exp_t e);
            logic acc;
            acc = 1'b0;
            for (int i = 0; i < 40 && !acc; i++) applyStimulus(1'b0, 1'b1, a, b, ci, s, ordy, e, acc);
            if (!acc) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: beat not accepted within 40 cycles", tag("accept"));
            end
        endtask

        task automatic drain();
            for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1'b1);
            checkEq(tag("drain outstanding"), sb.size(), 0);
        endtask

        task automatic checkIdle(input string what);
            checkEq(tag({what, " out_valid"}), 32'(out_valid), 0);
            checkEq(tag({what, " sum"}), 32'(sum), 0);
            checkEq(tag({what, " carry_out"}), 32'(carry_out), 0);
            checkEq(tag({what, " overflow"}), 32'(overflow), 0);
            checkEq(tag({what, " in_ready"}), 32'(in_ready), 1);
        endtask

        initial begin
            logic         acc, stalling;
            logic [W-1:0] ra, rb, held;
            logic         rc, rs;
            exp_t         e;
            int           start, sent, stalls;

            rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
            carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
            held = '0;

            tbl[0] = '{ONES,    W'(1),  1'b0, 1'b0, W'(0), 1'b1, 1'b0};
            tbl[1] = '{MAXP,    W'(1),  1'b0, 1'b0, MINN,  1'b0, 1'b1};
            tbl[2] = '{W'(0),   W'(0),  1'b1, 1'b0, W'(1), 1'b0, 1'b0};
            tbl[3] = '{W'(2),   W'(3),  1'b0, 1'b1, ONES,  1'b0, 1'b0};
            tbl[4] = '{MINN,    W'(1),  1'b0, 1'b1, MAXP,  1'b1, 1'b1};
            tbl[5] = '{W'(16),  W'(16), 1'b1, 1'b1, ONES,  1'b0, 1'b0};
            tbl[6] = '{MAXP,    MAXP,   1'b1, 1'b0, ONES,  1'b0, 1'b1};

            // Power-on reset with a beat presented, which must be dropped.
            repeat (2) applyStimulus(1'b1, 1'b1, ONES, ONES, 1'b1, 1'b0, 1'b0, model(ONES, ONES, 1'b1, 1'b0), acc);
            idle(1'b0);
            checkIdle("after reset");

            // Directed corners back to back with the sink always ready.
            start = cyc;
            foreach (tbl[i]) begin
                e.sum = tbl[i].sum; e.co = tbl[i].co; e.ov = tbl[i].ov; e.acc = 0; e.lat = 1'b1;
                sendBeat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, e);
            end
            checkEq(tag("table throughput cycles"), cyc - start, 7);
            drain();

            // Four beats; sink stalls for three cycles once the first result shows up.
            sent = 0; stalls = 0;
            for (int i = 0; i < 60 && (sent < 4 || sb.size() != 0); i++) begin
                @(negedge clk);
                stalling = (stalls > 0 && stalls < 3) || (stalls == 0 && out_valid);
                if (stalling && stalls == 0) held = sum;
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                driveAndCheck(1'b0, sent < 4, ra, rb, rc, rs, !stalling, model(ra, rb, rc, rs), acc);
                if (acc) sent++;
                if (stalling) begin
                    checkEq(tag("stall in_ready"), 32'(in_ready), 0);
                    checkEq(tag("stall out_valid"), 32'(out_valid), 1);
                    checkEq(tag("stall held sum"), 32'(sum), 32'(held));
                    stalls++;
                end
            end
            checkEq(tag("backpressure stall cycles"), stalls, 3);
            checkEq(tag("backpressure beats sent"), sent, 4);
            drain();

            // Reset with beats in flight while the sink is stalled; none may reappear.
            repeat (3) begin
                ra = W'($urandom); rb = W'($urandom);
                applyStimulus(1'b0, 1'b1, ra, rb, 1'b0, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), acc);
            end
            repeat (2) applyStimulus(1'b1, 1'b1, ONES, W'(1), 1'b0, 1'b0, 1'b1, model(ONES, W'(1), 1'b0, 1'b0), acc);
            idle(1'b0);
            checkIdle("mid-stream reset");
            repeat (12) idle(1'b1);

            // Random valid/ready traffic against the integer model.
            sent = 0;
            for (int i = 0; i < 20000 && sent < NRAND; i++) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                applyStimulus(1'b0, $urandom_range(0, 3) != 0, ra, rb, rc, rs,
                              $urandom_range(0, 3) != 0, model(ra, rb, rc, rs), acc);
                if (acc) sent++;
            end
            checkEq(tag("random beats sent"), sent, NRAND);
            drain();

            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < NCFG; i++) @(posedge clk);
        if (done_cnt < NCFG) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: finished configs %0d, expected %0d", done_cnt, NCFG);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
